// File: rtl/mimc_pkg.sv
// mimc_pkg: BN254 scalar-field modulus, sponge controller state encoding and a
// reduce-then-add helper for field elements.
package mimc_pkg;

    localparam int unsigned FE_BITS = 254;

    localparam logic [FE_BITS-1:0] P =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_ADD,
        ST_C_RST,
        ST_C_RUN,
        ST_SQ_OUT
    } state_t;

    // a is assumed canonical (< P); b may be any 254-bit value.
    function automatic logic [FE_BITS-1:0] mod_add(input logic [FE_BITS-1:0] a,
                                                   input logic [FE_BITS-1:0] b);
        logic [FE_BITS-1:0] r;
        logic [FE_BITS:0]   s;
        r = (b >= P) ? b - P : b;
        s = {1'b0, a} + {1'b0, r};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[FE_BITS-1:0];
    endfunction

endpackage

// File: rtl/mimc_mod_add.sv
// mimc_mod_add: combinational field addition acc + (din mod P) for the sponge
// absorb step. Non-254-bit widths use the modulus truncated/extended to N_BITS.
module mimc_mod_add
    import mimc_pkg::*;
#(
    parameter int unsigned N_BITS = 254
) (
    input  logic [N_BITS-1:0] acc,
    input  logic [N_BITS-1:0] din,
    output logic [N_BITS-1:0] sum
);

    generate
        if (N_BITS == FE_BITS) begin : g_field
            assign sum = mod_add(acc, din);
        end else begin : g_generic
            localparam logic [N_BITS-1:0] PM = N_BITS'(P);
            logic [N_BITS-1:0] r;
            logic [N_BITS:0]   s;
            always_comb begin
                r   = (din >= PM) ? din - PM : din;
                s   = {1'b0, acc} + {1'b0, r};
                sum = (s >= {1'b0, PM}) ? s[N_BITS-1:0] - PM : s[N_BITS-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/mimc_sponge_ctrl.sv
// mimc_sponge_ctrl: drives one external MiMC Feistel cipher as a sponge hash,
// absorbing a word stream and squeezing N_OUTPUTS digest words.
// Optional MIMC_SPONGE_CYCLE_COUNT_EN adds a saturating per-message cycle counter.
module mimc_sponge_ctrl
    import mimc_pkg::*;
#(
    parameter int unsigned N_BITS          = 254,
    parameter int unsigned N_OUTPUTS       = 1,
    parameter bit          KEY_WIDTH_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] key,
    input  logic [N_BITS-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [N_BITS-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic              ciph_rst,
    output logic              ciph_en,
    output logic [N_BITS-1:0] ciph_in_left,
    output logic [N_BITS-1:0] ciph_in_right,
    output logic [N_BITS-1:0] ciph_key,
    input  logic [N_BITS-1:0] ciph_out_left,
    input  logic [N_BITS-1:0] ciph_out_right,
    input  logic              ciph_done
`ifdef MIMC_SPONGE_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam logic [N_BITS-1:0] PM = N_BITS'(P);

    state_t            state, state_nx;
    logic [N_BITS-1:0] xl, xr, key_q, din_q, sum;
    logic              last_q, rej_q, err_q;
    logic [4:0]        cnt;
    logic              in_hs, out_hs, first_hs, key_bad, cnt_done;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign first_hs = in_hs && (state == ST_IDLE);
    assign key_bad  = KEY_WIDTH_CHECK && (key >= PM);
    assign cnt_done = (cnt + 5'd1) == 5'(N_OUTPUTS);

    mimc_mod_add #(.N_BITS(N_BITS)) u_add (
        .acc (xl),
        .din (din_q),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A rejected message parks in ABSORB (rej_q set) and only drains input words.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (in_hs) begin
                    if (!key_bad) begin
                        state_nx = ST_ADD;
                    end else if (!in_last) begin
                        state_nx = ST_ABSORB;
                    end
                end
            end
            ST_ABSORB: begin
                if (in_hs) begin
                    if (!rej_q) begin
                        state_nx = ST_ADD;
                    end else if (in_last) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_ADD:   state_nx = ST_C_RST;
            ST_C_RST: state_nx = ST_C_RUN;
            ST_C_RUN: begin
                if (ciph_done) begin
                    state_nx = last_q ? ST_SQ_OUT : ST_ABSORB;
                end
            end
            ST_SQ_OUT: begin
                if (out_hs) begin
                    state_nx = cnt_done ? ST_IDLE : ST_C_RST;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake and cipher controls are forced to their reset values while rst is high.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ciph_rst  = 1'b1;
        ciph_en   = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE, ST_ABSORB: in_ready = 1'b1;
                ST_C_RUN: begin
                    ciph_rst = 1'b0;
                    ciph_en  = 1'b1;
                end
                ST_SQ_OUT: out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xl     <= '0;
            xr     <= '0;
            key_q  <= '0;
            din_q  <= '0;
            last_q <= 1'b0;
            rej_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (in_hs) begin
                din_q  <= in_data;
                last_q <= in_last;
            end
            if (first_hs) begin
                key_q <= key;
                err_q <= key_bad;
                rej_q <= key_bad && !in_last;
                xl    <= '0;
                xr    <= '0;
                cnt   <= '0;
            end
            if (state == ST_ABSORB && in_hs && rej_q && in_last) begin
                rej_q <= 1'b0;
            end
            if (state == ST_ADD) begin
                xl <= sum;
            end
            if (state == ST_C_RUN && ciph_done) begin
                xl <= ciph_out_left;
                xr <= ciph_out_right;
            end
            if (out_hs) begin
                cnt <= cnt + 5'd1;
            end
        end
    end

`ifdef MIMC_SPONGE_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (first_hs) begin
            cycle_count <= '0;
        end else if (busy && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

    assign busy          = (state != ST_IDLE);
    assign err           = err_q;
    assign out_data      = xl;
    assign ciph_in_left  = xl;
    assign ciph_in_right = xr;
    assign ciph_key      = key_q;

endmodule

// File: tb/tb_mimc_sponge_ctrl.sv
// Testbench for mimc_sponge_ctrl: a stand-in keyed permutation plays the cipher,
// and a plain-arithmetic sponge model supplies every expected digest.
module tb_mimc_sponge_ctrl;
    import mimc_pkg::*;

    localparam int unsigned NB   = 254;
    localparam int unsigned NOUT = 3;
    typedef logic [NB-1:0] fe_t;
    localparam logic [511:0] PW = {258'd0, P};

    logic clk = 1'b0;
    logic rst = 1'b1;
    fe_t  key = '0;
    fe_t  in_data = '0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, busy, err, ciph_rst, ciph_en;
    fe_t  out_data, ciph_in_left, ciph_in_right, ciph_key, ciph_out_left, ciph_out_right;
    logic ciph_done;
`ifdef MIMC_SPONGE_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    always #5 clk = ~clk;

    mimc_sponge_ctrl #(.N_BITS(NB), .N_OUTPUTS(NOUT), .KEY_WIDTH_CHECK(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .err            (err),
        .ciph_rst       (ciph_rst),
        .ciph_en        (ciph_en),
        .ciph_in_left   (ciph_in_left),
        .ciph_in_right  (ciph_in_right),
        .ciph_key       (ciph_key),
        .ciph_out_left  (ciph_out_left),
        .ciph_out_right (ciph_out_right),
        .ciph_done      (ciph_done)
`ifdef MIMC_SPONGE_CYCLE_COUNT_EN
        ,
        .cycle_count    (cycle_count)
`endif
    );

    // Stand-in keyed Feistel step: L' = R + (L + k + 3)^2 mod P, R' = L.
    function automatic void toy_perm(input fe_t l, input fe_t r, input fe_t k,
                                     output fe_t nl, output fe_t nr);
        logic [511:0] t;
        t  = ({258'd0, l} + {258'd0, k} + 512'd3) % PW;
        t  = (t * t) % PW;
        t  = (t + {258'd0, r}) % PW;
        nl = t[NB-1:0];
        nr = l;
    endfunction

    // Cipher stand-in with a random latency per run; done is a level held until rst.
    logic        c_done = 1'b0;
    fe_t         c_ol = '0, c_or = '0, c_nl, c_nr;
    int unsigned c_cnt = 0, c_lat = 0;
    assign ciph_done      = c_done;
    assign ciph_out_left  = c_ol;
    assign ciph_out_right = c_or;

    always @(posedge clk) begin
        if (ciph_rst) begin
            c_done <= 1'b0;
            c_cnt  <= 0;
            c_lat  <= $urandom_range(0, 5);
        end else if (ciph_en && !c_done) begin
            if (c_cnt == c_lat) begin
                toy_perm(ciph_in_left, ciph_in_right, ciph_key, c_nl, c_nr);
                c_ol   <= c_nl;
                c_or   <= c_nr;
                c_done <= 1'b1;
            end else begin
                c_cnt <= c_cnt + 1;
            end
        end
    end

    // Run/beat counters and cipher-protocol monitor.
    int unsigned runs = 0, ov_cycles = 0, proto_bad = 0;
    logic prev_rst = 1'b1, prev_en = 1'b0;
    fe_t  run_l, run_r, run_k;
    always @(posedge clk) begin
        if (ciph_en && !prev_en) begin
            runs = runs + 1;
            if (!prev_rst || ciph_rst) proto_bad = proto_bad + 1;
            run_l = ciph_in_left;
            run_r = ciph_in_right;
            run_k = ciph_key;
        end else if (ciph_en) begin
            if (ciph_in_left !== run_l || ciph_in_right !== run_r || ciph_key !== run_k)
                proto_bad = proto_bad + 1;
        end
        if (ciph_en && ciph_rst) proto_bad = proto_bad + 1;
        if (out_valid) ov_cycles = ov_cycles + 1;
        prev_rst <= ciph_rst;
        prev_en  <= ciph_en;
    end

    int unsigned errors = 0, checks = 0;
    fe_t         msg [8];
    int unsigned msg_len;
    fe_t         expd [NOUT];
    fe_t         obs [NOUT];
    fe_t         digest0;

    task automatic check(input string tag, input fe_t observed, input fe_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic fe_t rand_fe();
        fe_t v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | fe_t'($urandom());
        return v;
    endfunction

    task automatic model_hash(input fe_t k);
        fe_t xl = '0, xr = '0, nl, nr;
        for (int unsigned i = 0; i < msg_len; i++) begin
            xl = fe_t'(({258'd0, xl} + ({258'd0, msg[i]} % PW)) % PW);
            toy_perm(xl, xr, k, nl, nr);
            xl = nl;
            xr = nr;
        end
        for (int unsigned j = 0; j < NOUT; j++) begin
            if (j > 0) begin
                toy_perm(xl, xr, k, nl, nr);
                xl = nl;
                xr = nr;
            end
            expd[j] = xl;
        end
    endtask

    task automatic send_word(input fe_t w, input logic last, input fe_t kdrive);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        key      = kdrive;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_accept", fe_t'(in_ready), fe_t'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = rand_fe();
        key      = rand_fe();
    endtask

    task automatic recv_outputs(input int unsigned smin, input int unsigned smax);
        for (int unsigned j = 0; j < NOUT; j++) begin
            int unsigned n = 0;
            int unsigned stall = $urandom_range(smin, smax);
            out_ready = 1'b0;
            while (!out_valid && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("out_valid_seen", fe_t'(out_valid), fe_t'(1'b1));
            for (int unsigned s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_data", out_data, expd[j]);
            end
            check("out_data", out_data, expd[j]);
            obs[j]    = out_data;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("out_valid_drop", fe_t'(out_valid), fe_t'(1'b0));
        check("busy_end", fe_t'(busy), fe_t'(1'b0));
    endtask

    task automatic run_msg(input fe_t k, input int unsigned gap, input bit fixed_gap,
                           input int unsigned smin, input int unsigned smax);
        int unsigned r0 = runs;
        model_hash(k);
        for (int unsigned i = 0; i < msg_len; i++) begin
            send_word(msg[i], (i == msg_len - 1), (i == 0) ? k : rand_fe());
            if (i != msg_len - 1) repeat (fixed_gap ? gap : $urandom_range(0, gap)) @(negedge clk);
        end
        recv_outputs(smin, smax);
        check("cipher_runs", fe_t'(runs - r0), fe_t'(msg_len + NOUT - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0, o0, n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", fe_t'(in_ready), fe_t'(1'b0));
        check("rst_out_valid", fe_t'(out_valid), fe_t'(1'b0));
        check("rst_ciph_rst", fe_t'(ciph_rst), fe_t'(1'b1));
        check("rst_ciph_en", fe_t'(ciph_en), fe_t'(1'b0));
        check("rst_busy", fe_t'(busy), fe_t'(1'b0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", fe_t'(in_ready), fe_t'(1'b1));
        check("idle_err", fe_t'(err), fe_t'(1'b0));
        check("idle_out_data", out_data, '0);

        // Single zero word, key 0
        msg[0] = '0; msg_len = 1;
        run_msg('0, 0, 1'b1, 0, 2);
        digest0 = obs[0];

        // Non-canonical P must hash like 0
        msg[0] = P; msg_len = 1;
        run_msg('0, 0, 1'b1, 0, 2);
        check("noncanon_equal", obs[0], digest0);

        // {1,2,3}, key 7, 5-cycle gaps, 10-cycle output stalls
        msg[0] = fe_t'(1); msg[1] = fe_t'(2); msg[2] = fe_t'(3); msg_len = 3;
        run_msg(fe_t'(7), 5, 1'b1, 10, 10);
        check("beats_distinct", fe_t'((obs[0] != obs[1]) && (obs[1] != obs[2])), fe_t'(1'b1));

        // Randomized messages
        for (int t = 0; t < 6; t++) begin
            msg_len = $urandom_range(1, 5);
            for (int unsigned i = 0; i < msg_len; i++) msg[i] = rand_fe();
            run_msg(rand_fe() % P, 3, 1'b0, 0, 4);
        end

        // Reset during the cipher run of word 2
        o0 = ov_cycles;
        send_word(rand_fe(), 1'b0, fe_t'(9));
        send_word(rand_fe(), 1'b0, rand_fe());
        n = 0;
        while (!ciph_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrun_en", fe_t'(ciph_en), fe_t'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", fe_t'(busy), fe_t'(1'b0));
        check("abort_out_valid", fe_t'(out_valid), fe_t'(1'b0));
        check("abort_ciph_rst", fe_t'(ciph_rst), fe_t'(1'b1));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_output", fe_t'(ov_cycles - o0), '0);
        msg[0] = fe_t'(1); msg_len = 1;
        run_msg('0, 0, 1'b1, 0, 2);

        // Key = P rejects a three-word message
        r0 = runs;
        o0 = ov_cycles;
        send_word(fe_t'(5), 1'b0, P);
        check("reject_err", fe_t'(err), fe_t'(1'b1));
        check("reject_busy", fe_t'(busy), fe_t'(1'b1));
        send_word(fe_t'(6), 1'b0, rand_fe());
        send_word(fe_t'(7), 1'b1, rand_fe());
        check("reject_idle", fe_t'(busy), fe_t'(1'b0));
        repeat (10) @(negedge clk);
        check("reject_err_sticky", fe_t'(err), fe_t'(1'b1));
        check("reject_runs", fe_t'(runs - r0), '0);
        check("reject_no_output", fe_t'(ov_cycles - o0), '0);

        // Single-word rejected message with key just above P
        send_word(fe_t'(1), 1'b1, P + fe_t'(3));
        check("reject1_idle", fe_t'(busy), fe_t'(1'b0));
        check("reject1_err", fe_t'(err), fe_t'(1'b1));
        check("reject1_runs", fe_t'(runs - r0), '0);

        // A valid message clears err and hashes normally
        msg[0] = fe_t'(11); msg[1] = fe_t'(22); msg_len = 2;
        run_msg(P - fe_t'(1), 2, 1'b0, 0, 3);
        check("err_cleared", fe_t'(err), fe_t'(1'b0));

        check("cipher_protocol", fe_t'(proto_bad), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
